// File: rtl/irq_ctl.sv
// irq_ctl: edge-detecting, maskable, fixed-priority interrupt requester for pc_gen.
// Latency: a request is visible on pending the cycle a line is first sampled high;
// TAKE follows one cycle later (add 2 cycles when IRQ_SYNC_EN is defined).
// Backpressure: pause holds the IDLE->TAKE decision and the TAKE state (vector held).
//
// Optional feature macro: IRQ_SYNC_EN (2-flop input synchronizer per line).
//
// Ports:
//   clock, rst          clock / asynchronous active-high reset
//   irq_lines           external requests, rising edge = request
//   pause               pipeline stall shared with pc_gen
//   pc                  PC to resume at after the ISR
//   eret                one-cycle ISR-return pulse
//   mask_wr, mask_data  mask register load (1 = line enabled)
//   pc_prectl           PC_IGN / PC_IRQ / PC_KEP toward pc_gen
//   irq_addr            selected vector address
//   zz_spc              saved return PC
//   in_service          ISR active
//   pending             pending flags

`ifndef PC_IGN
`define PC_IGN 4'b0000
`endif
`ifndef PC_IRQ
`define PC_IRQ 4'b0100
`endif
`ifndef PC_KEP
`define PC_KEP 4'b0011
`endif

module irq_ctl #(
  parameter int          NUM_IRQ    = 4,
  parameter logic [31:0] VEC_BASE   = 32'h0000_0050,
  parameter logic [31:0] VEC_STRIDE = 32'h0000_0010
) (
  input  logic               clock,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_lines,
  input  logic               pause,
  input  logic [31:0]        pc,
  input  logic               eret,
  input  logic               mask_wr,
  input  logic [NUM_IRQ-1:0] mask_data,
  output logic [3:0]         pc_prectl,
  output logic [31:0]        irq_addr,
  output logic [31:0]        zz_spc,
  output logic               in_service,
  output logic [NUM_IRQ-1:0] pending
);

  typedef enum logic [1:0] {S_IDLE, S_TAKE, S_ISR, S_RET} state_t;

  state_t             state, state_nxt;
  logic [NUM_IRQ-1:0] mask;
  logic [NUM_IRQ-1:0] line_cur;   // line value seen by the edge detector
  logic [NUM_IRQ-1:0] hist;       // one-cycle delayed copy of line_cur
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] active;
  logic [NUM_IRQ-1:0] clr_vec;
  logic [2:0]         idx;
  logic [2:0]         sel_idx;
  logic               take_start;
  logic               take_done;

`ifdef IRQ_SYNC_EN
  logic [NUM_IRQ-1:0] sync1, sync2;

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= irq_lines;
      sync2 <= sync1;
    end
  end

  assign line_cur = sync2;
`else
  // Lines are assumed synchronous to clock in this build.
  assign line_cur = irq_lines;
`endif

  assign rise   = line_cur & ~hist;
  assign active = pending & mask;

  // Lowest index wins: scan high to low so the last hit is the lowest.
  always_comb begin
    sel_idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (active[i]) sel_idx = 3'(i);
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    pc_prectl  = `PC_IGN;
    take_start = 1'b0;
    take_done  = 1'b0;
    case (state)
      S_IDLE: begin
        if ((|active) && !pause) begin
          take_start = 1'b1;
          state_nxt  = S_TAKE;
        end
      end
      S_TAKE: begin
        pc_prectl = `PC_IRQ;
        if (!pause) begin
          take_done = 1'b1;
          state_nxt = S_ISR;
        end
      end
      S_ISR: begin
        if (eret) state_nxt = S_RET;
      end
      S_RET: begin
        pc_prectl = `PC_KEP;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // A new edge on the line being cleared takes priority over the clear.
  assign clr_vec = take_done ? (NUM_IRQ'(1) << idx) : '0;

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      hist       <= '0;
      pending    <= '0;
      mask       <= '0;
      idx        <= '0;
      irq_addr   <= '0;
      zz_spc     <= '0;
      in_service <= 1'b0;
    end else begin
      hist    <= line_cur;
      pending <= (pending & ~clr_vec) | rise;
      // The arbitration above used the pre-write mask, so a same-cycle write
      // only affects later decisions.
      if (mask_wr) mask <= mask_data;
      if (take_start) begin
        idx      <= sel_idx;
        irq_addr <= VEC_BASE + VEC_STRIDE * {29'd0, sel_idx};
      end
      if (take_done) begin
        zz_spc     <= pc;
        in_service <= 1'b1;
      end else if (state == S_RET) begin
        in_service <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_irq_ctl.sv
`ifndef PC_IGN
`define PC_IGN 4'b0000
`endif
`ifndef PC_IRQ
`define PC_IRQ 4'b0100
`endif
`ifndef PC_KEP
`define PC_KEP 4'b0011
`endif

module tb_irq_ctl;

  logic        clock = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  irq_lines = '0;
  logic        pause = 1'b0;
  logic [31:0] pc = '0;
  logic        eret = 1'b0;
  logic        mask_wr = 1'b0;
  logic [3:0]  mask_data = '0;
  logic [3:0]  pc_prectl;
  logic [31:0] irq_addr;
  logic [31:0] zz_spc;
  logic        in_service;
  logic [3:0]  pending;

  int n_checks = 0;
  int n_fail = 0;

  irq_ctl #(.NUM_IRQ(4), .VEC_BASE(32'h50), .VEC_STRIDE(32'h10)) dut (
    .clock(clock), .rst(rst), .irq_lines(irq_lines), .pause(pause), .pc(pc),
    .eret(eret), .mask_wr(mask_wr), .mask_data(mask_data), .pc_prectl(pc_prectl),
    .irq_addr(irq_addr), .zz_spc(zz_spc), .in_service(in_service), .pending(pending)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0]  lines;
    logic        pause;
    logic        eret;
    logic        mask_wr;
    logic [3:0]  mask_data;
    logic [31:0] pc;
    logic [3:0]  e_prectl;
    logic [3:0]  e_pend;
    logic        e_ins;
    logic [31:0] e_addr;
    logic [31:0] e_zz;
  } vec_t;

  vec_t vt[16];

  // Reference model: phase of the interrupt handshake plus architectural registers.
  localparam int M_IDLE = 0, M_PRESENT = 1, M_SERVE = 2, M_RETURN = 3;
  int          m_phase;
  int          m_line;
  logic [3:0]  m_pend, m_mask, m_prev;
  logic [31:0] m_addr, m_zz;
  logic        m_ins;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [3:0] e_pc, input logic [3:0] e_pend,
                           input logic e_ins, input logic [31:0] e_addr, input logic [31:0] e_zz);
    chk({tag, ".prectl"}, {28'd0, pc_prectl}, {28'd0, e_pc});
    chk({tag, ".pending"}, {28'd0, pending}, {28'd0, e_pend});
    chk({tag, ".in_service"}, {31'd0, in_service}, {31'd0, e_ins});
    chk({tag, ".irq_addr"}, irq_addr, e_addr);
    chk({tag, ".zz_spc"}, zz_spc, e_zz);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    irq_lines = '0; pause = 1'b0; pc = '0; eret = 1'b0; mask_wr = 1'b0; mask_data = '0;
    repeat (2) @(posedge clock);
    #1;
    rst = 1'b0;
  endtask

  function automatic logic [3:0] model_prectl();
    if (m_phase == M_PRESENT) return `PC_IRQ;
    if (m_phase == M_RETURN) return `PC_KEP;
    return `PC_IGN;
  endfunction

  // Advance the model across one rising edge using the inputs currently driven.
  task automatic model_step();
    logic [3:0] edges, cleared, ready;
    edges   = irq_lines & ~m_prev;
    cleared = '0;
    ready   = m_pend & m_mask;
    case (m_phase)
      M_IDLE: if (ready != 0 && !pause) begin
        m_line = 0;
        while (!ready[m_line]) m_line++;
        m_addr  = 32'h50 + 32'(m_line) * 16;
        m_phase = M_PRESENT;
      end
      M_PRESENT: if (!pause) begin
        m_zz    = pc;
        cleared = 4'(1 << m_line);
        m_ins   = 1'b1;
        m_phase = M_SERVE;
      end
      M_SERVE: if (eret) m_phase = M_RETURN;
      default: begin
        m_ins   = 1'b0;
        m_phase = M_IDLE;
      end
    endcase
    m_pend = (m_pend & ~cleared) | edges;
    if (mask_wr) m_mask = mask_data;
    m_prev = irq_lines;
  endtask

  initial begin
    // Scenarios 1, 2 and eret-outside-ISR, starting right after reset release.
    vt[0]  = '{4'h0, 0, 0, 1, 4'hF, 32'h0,   `PC_IGN, 4'h0, 0, 32'h00, 32'h000};
    vt[1]  = '{4'h4, 0, 0, 0, 4'h0, 32'h0,   `PC_IGN, 4'h4, 0, 32'h00, 32'h000};
    vt[2]  = '{4'h4, 0, 0, 0, 4'h0, 32'h0,   `PC_IRQ, 4'h4, 0, 32'h70, 32'h000};
    vt[3]  = '{4'h0, 0, 0, 0, 4'h0, 32'h400, `PC_IGN, 4'h0, 1, 32'h70, 32'h400};
    vt[4]  = '{4'h0, 0, 1, 0, 4'h0, 32'h0,   `PC_KEP, 4'h0, 1, 32'h70, 32'h400};
    vt[5]  = '{4'h0, 0, 0, 0, 4'h0, 32'h0,   `PC_IGN, 4'h0, 0, 32'h70, 32'h400};
    vt[6]  = '{4'hA, 0, 0, 0, 4'h0, 32'h0,   `PC_IGN, 4'hA, 0, 32'h70, 32'h400};
    vt[7]  = '{4'hA, 0, 0, 0, 4'h0, 32'h0,   `PC_IRQ, 4'hA, 0, 32'h60, 32'h400};
    vt[8]  = '{4'hA, 0, 0, 0, 4'h0, 32'h123, `PC_IGN, 4'h8, 1, 32'h60, 32'h123};
    vt[9]  = '{4'hA, 0, 1, 0, 4'h0, 32'h0,   `PC_KEP, 4'h8, 1, 32'h60, 32'h123};
    vt[10] = '{4'hA, 0, 0, 0, 4'h0, 32'h0,   `PC_IGN, 4'h8, 0, 32'h60, 32'h123};
    vt[11] = '{4'hA, 0, 0, 0, 4'h0, 32'h0,   `PC_IRQ, 4'h8, 0, 32'h80, 32'h123};
    vt[12] = '{4'h0, 0, 0, 0, 4'h0, 32'h777, `PC_IGN, 4'h0, 1, 32'h80, 32'h777};
    vt[13] = '{4'h0, 0, 1, 0, 4'h0, 32'h0,   `PC_KEP, 4'h0, 1, 32'h80, 32'h777};
    vt[14] = '{4'h0, 0, 1, 0, 4'h0, 32'h0,   `PC_IGN, 4'h0, 0, 32'h80, 32'h777};
    vt[15] = '{4'h0, 0, 1, 0, 4'h0, 32'h0,   `PC_IGN, 4'h0, 0, 32'h80, 32'h777};

    // Reset state, sampled while rst is still asserted.
    @(posedge clock); #1;
    check_all("reset", `PC_IGN, 4'h0, 1'b0, 32'h0, 32'h0);
    do_reset();

    for (int k = 0; k < 16; k++) begin
      irq_lines = vt[k].lines; pause = vt[k].pause; eret = vt[k].eret;
      mask_wr = vt[k].mask_wr; mask_data = vt[k].mask_data; pc = vt[k].pc;
      cyc();
      check_all($sformatf("vec%0d", k), vt[k].e_prectl, vt[k].e_pend, vt[k].e_ins,
                vt[k].e_addr, vt[k].e_zz);
    end
    eret = 1'b0;

    // Masked line latches pending, taken only after unmasking (old mask on write edge).
    do_reset();
    irq_lines = 4'h1; cyc();
    check_all("mask.latch", `PC_IGN, 4'h1, 0, 32'h0, 32'h0);
    irq_lines = 4'h0; cyc(); cyc();
    check_all("mask.hold", `PC_IGN, 4'h1, 0, 32'h0, 32'h0);
    mask_wr = 1'b1; mask_data = 4'h1; cyc();
    check_all("mask.wr_edge", `PC_IGN, 4'h1, 0, 32'h0, 32'h0);
    mask_wr = 1'b0; cyc();
    check_all("mask.take", `PC_IRQ, 4'h1, 0, 32'h50, 32'h0);

    // New edge on the line being cleared: set wins.
    irq_lines = 4'h1; pc = 32'h55; cyc();
    check_all("setwins", `PC_IGN, 4'h1, 1, 32'h50, 32'h55);
    eret = 1'b1; cyc(); eret = 1'b0;
    check_all("setwins.ret", `PC_KEP, 4'h1, 1, 32'h50, 32'h55);
    irq_lines = 4'h0; cyc();
    check_all("setwins.idle", `PC_IGN, 4'h1, 0, 32'h50, 32'h55);
    cyc();
    check_all("pause.take", `PC_IRQ, 4'h1, 0, 32'h50, 32'h55);

    // Pause held in TAKE for 3 cycles: vector held, zz_spc untouched.
    pause = 1'b1;
    for (int k = 0; k < 3; k++) begin
      pc = 32'h1000 + 32'(k); cyc();
      check_all($sformatf("pause%0d", k), `PC_IRQ, 4'h1, 0, 32'h50, 32'h55);
    end
    pause = 1'b0; pc = 32'h999; cyc();
    check_all("pause.release", `PC_IGN, 4'h0, 1, 32'h50, 32'h999);

    // Reset mid-ISR with another line pending: values clear without a clock edge.
    irq_lines = 4'h2; cyc();
    check_all("isr.newpend", `PC_IGN, 4'h2, 1, 32'h50, 32'h999);
    rst = 1'b1; #1;
    check_all("midreset", `PC_IGN, 4'h0, 0, 32'h0, 32'h0);
    do_reset();

    // Randomized run against the reference model.
    m_phase = M_IDLE; m_line = 0; m_pend = '0; m_mask = '0; m_prev = '0;
    m_addr = '0; m_zz = '0; m_ins = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) irq_lines = 4'($urandom);
      pause     = ($urandom_range(0, 3) == 0);
      eret      = ($urandom_range(0, 4) == 0);
      mask_wr   = ($urandom_range(0, 11) == 0);
      mask_data = 4'($urandom);
      pc        = $urandom;
      model_step();
      cyc();
      check_all("rand", model_prectl(), m_pend, m_ins, m_addr, m_zz);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
